// File: rtl/deconv_pkg.sv
// Shared definitions for the deconvolution layer scheduler.
//   state_t    : scheduler FSM encoding
//   CNT_WIDTH  : width of group/channel counters and their config fields
//   n_col_out  : output columns produced per (kernel group, channel) step
package deconv_pkg;

    localparam int CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD_W = 3'd2,
        S_LOAD_F = 3'd3,
        S_RUN    = 3'd4,
        S_NEXT   = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    // Columns of the transposed-conv output: overlapping kernel footprints
    // share (weight - stride) columns between neighbouring input pixels.
    function automatic int n_col_out(input int feat, input int wgt, input int stride);
        return feat * wgt - (wgt - stride) * (feat - 1);
    endfunction

endpackage

// File: rtl/deconv_addr_gen.sv
// Base-address generator for weight and feature BRAM blocks.
//   i_grp, i_ch   : current kernel group / input channel
//   i_num_ch      : channels per kernel (already forced to >= 1)
//   o_wgt_addr    : (grp*num_ch + ch) * WGT_STEP, wrapped to ADDRESS_WIDTH
//   o_feat_addr   : ch * FEAT_STEP, wrapped to ADDRESS_WIDTH
module deconv_addr_gen
    import deconv_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int WGT_STEP      = 9,
    parameter int FEAT_STEP     = 4
) (
    input  logic [CNT_WIDTH-1:0]     i_grp,
    input  logic [CNT_WIDTH-1:0]     i_ch,
    input  logic [CNT_WIDTH-1:0]     i_num_ch,
    output logic [ADDRESS_WIDTH-1:0] o_wgt_addr,
    output logic [ADDRESS_WIDTH-1:0] o_feat_addr
);

    logic [31:0] w_blk_idx;

    assign w_blk_idx   = 32'(i_grp) * 32'(i_num_ch) + 32'(i_ch);
    // Low bits of a product depend only on low bits of the operands,
    // so truncating the 32-bit result gives the wrapped address.
    assign o_wgt_addr  = ADDRESS_WIDTH'(w_blk_idx * 32'(WGT_STEP));
    assign o_feat_addr = ADDRESS_WIDTH'(32'(i_ch) * 32'(FEAT_STEP));

endmodule

// File: rtl/deconv_layer_scheduler.sv
// Sequences one deconvolution layer: outer loop over kernel groups, inner
// loop over input channels; per step loads weights, loads features, then
// counts fully-valid output columns from the 4 sub-cores.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start with
// i_num_groups/i_num_channels config; weight and feature load req/addr/done
// handshakes; i_deconv_valid per-sub-core column valids; o_acc_clear/o_acc_en
// accumulator pulses; o_busy/o_done status; o_err_desync sticky error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for i_start
// CLEAR    | one-cycle accumulator clear at the start of a kernel group
// LOAD_W   | weight block request held until i_wgt_load_done
// LOAD_F   | feature channel request held until i_feat_load_done
// RUN      | counting columns where all four sub-cores are valid
// NEXT     | advance channel / group counters
// FIN      | one-cycle done pulse
module deconv_layer_scheduler
    import deconv_pkg::*;
#(
    parameter int SIZE_OF_FEATURE = 2,
    parameter int SIZE_OF_WEIGHT  = 3,
    parameter int STRIDE          = 1,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int WGT_STEP        = 9,
    parameter int FEAT_STEP       = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [CNT_WIDTH-1:0]     i_num_groups,
    input  logic [CNT_WIDTH-1:0]     i_num_channels,
    output logic                     o_wgt_load_req,
    output logic [ADDRESS_WIDTH-1:0] o_wgt_base_addr,
    input  logic                     i_wgt_load_done,
    output logic                     o_feat_load_req,
    output logic [ADDRESS_WIDTH-1:0] o_feat_base_addr,
    input  logic                     i_feat_load_done,
    input  logic [3:0]               i_deconv_valid,
    output logic                     o_acc_clear,
    output logic                     o_acc_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err_desync
);

    localparam int                   N_COL_OUT = n_col_out(SIZE_OF_FEATURE, SIZE_OF_WEIGHT, STRIDE);
    localparam logic [CNT_WIDTH-1:0] COL_LAST  = CNT_WIDTH'(N_COL_OUT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_grp;
    logic [CNT_WIDTH-1:0] r_ch;
    logic [CNT_WIDTH-1:0] r_num_grp;
    logic [CNT_WIDTH-1:0] r_num_ch;
    logic [CNT_WIDTH-1:0] r_col_cnt;
    logic                 r_acc_en;
    logic                 r_err_desync;
    logic                 w_col_event;
    logic                 w_desync;
    logic                 w_last_col;
    logic                 w_last_ch;
    logic                 w_last_grp;

    assign w_col_event = (r_state == S_RUN) && (i_deconv_valid == 4'b1111);
    assign w_desync    = (r_state == S_RUN) && (i_deconv_valid != 4'b0000) &&
                         (i_deconv_valid != 4'b1111);
    assign w_last_col  = (r_col_cnt == COL_LAST);
    assign w_last_ch   = (r_ch == r_num_ch - ONE);
    assign w_last_grp  = (r_grp == r_num_grp - ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next_state = S_CLEAR;
            S_CLEAR:  w_next_state = S_LOAD_W;
            S_LOAD_W: if (i_wgt_load_done) w_next_state = S_LOAD_F;
            S_LOAD_F: if (i_feat_load_done) w_next_state = S_RUN;
            S_RUN:    if (w_col_event && w_last_col) w_next_state = S_NEXT;
            S_NEXT: begin
                if (!w_last_ch)       w_next_state = S_LOAD_W;
                else if (!w_last_grp) w_next_state = S_CLEAR;
                else                  w_next_state = S_FIN;
            end
            S_FIN:    w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_wgt_load_req  = 1'b0;
        o_feat_load_req = 1'b0;
        o_acc_clear     = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            S_CLEAR:  o_acc_clear     = 1'b1;
            S_LOAD_W: o_wgt_load_req  = 1'b1;
            S_LOAD_F: o_feat_load_req = 1'b1;
            S_FIN:    o_done          = 1'b1;
            default:  ;
        endcase
        o_busy = (r_state != S_IDLE);
    end

    assign o_acc_en     = r_acc_en;
    assign o_err_desync = r_err_desync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grp        <= '0;
            r_ch         <= '0;
            r_num_grp    <= '0;
            r_num_ch     <= '0;
            r_col_cnt    <= '0;
            r_acc_en     <= 1'b0;
            r_err_desync <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_grp <= (i_num_groups == '0)   ? ONE : i_num_groups;
                        r_num_ch  <= (i_num_channels == '0) ? ONE : i_num_channels;
                        r_grp     <= '0;
                        r_ch      <= '0;
                        r_col_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_col_event) begin
                        r_col_cnt <= w_last_col ? '0 : r_col_cnt + ONE;
                    end
                end
                S_NEXT: begin
                    if (!w_last_ch) begin
                        r_ch <= r_ch + ONE;
                    end else begin
                        r_ch <= '0;
                        if (!w_last_grp) begin
                            r_grp <= r_grp + ONE;
                        end
                    end
                end
                default: ;
            endcase
            r_acc_en <= w_col_event;
            if (w_desync) begin
                r_err_desync <= 1'b1;
            end
        end
    end

    deconv_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .WGT_STEP      (WGT_STEP),
        .FEAT_STEP     (FEAT_STEP)
    ) u_addr_gen (
        .i_grp       (r_grp),
        .i_ch        (r_ch),
        .i_num_ch    (r_num_ch),
        .o_wgt_addr  (o_wgt_base_addr),
        .o_feat_addr (o_feat_base_addr)
    );

endmodule
